// File: rtl/cpu_sequencer.sv
// Phase sequencer for the multicycle MIPS-subset CPU: fetch, decode, execute
// handshake and vectored exception entry with configurable memory latency.
module cpu_sequencer #(
    parameter int unsigned MEM_WAIT = 1,
    parameter int unsigned N_EXC    = 2,
    parameter logic [7:0]  VEC_BASE = 8'd253,
    localparam int unsigned CAUSE_W = $clog2(N_EXC + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [5:0]         opcode,
    input  logic [5:0]         funct,
    input  logic               exec_done,
    input  logic [N_EXC-1:0]   exc_req,
    output logic               pc_write,
    output logic [1:0]         pc_src,
    output logic               ir_write,
    output logic               ab_write,
    output logic               epc_write,
    output logic [1:0]         mem_addr_sel,
    output logic [7:0]         vec_addr,
    output logic               exec_start,
    output logic [2:0]         exec_class,
    output logic [CAUSE_W-1:0] exc_cause,
    output logic               reset_out
);

    localparam int unsigned CNT_W = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_WAIT);

    localparam logic [2:0] CLS_R_ALU = 3'd0;
    localparam logic [2:0] CLS_I_ALU = 3'd1;
    localparam logic [2:0] CLS_BR    = 3'd2;
    localparam logic [2:0] CLS_LOAD  = 3'd3;
    localparam logic [2:0] CLS_STORE = 3'd4;
    localparam logic [2:0] CLS_JUMP  = 3'd5;
    localparam logic [2:0] CLS_MDIV  = 3'd6;
    localparam logic [2:0] CLS_SPEC  = 3'd7;

    typedef enum logic [2:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_EXC_SAVE,
        S_EXC_VEC
    } state_t;

    state_t             state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [2:0]         class_nxt;
    logic [CAUSE_W-1:0] cause_nxt;
    logic [CAUSE_W-1:0] req_cause;
    logic               nxt_last;
    logic [3:0]         dec;

    // Returns {legal, exec_class} for the instruction in IR.
    function automatic logic [3:0] decode(input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] r;
        r = 4'b0;
        case (op)
            6'h00: begin
                case (fn)
                    6'h20, 6'h24, 6'h00, 6'h04, 6'h2A,
                    6'h03, 6'h07, 6'h02, 6'h22:        r = {1'b1, CLS_R_ALU};
                    6'h1A, 6'h18:                      r = {1'b1, CLS_MDIV};
                    6'h08, 6'h10, 6'h12, 6'h0D,
                    6'h13, 6'h05:                      r = {1'b1, CLS_SPEC};
                    default:                           r = 4'b0;
                endcase
            end
            6'h08, 6'h09, 6'h0A, 6'h0F:                r = {1'b1, CLS_I_ALU};
            6'h04, 6'h05, 6'h06, 6'h07, 6'h01:         r = {1'b1, CLS_BR};
            6'h20, 6'h21, 6'h23:                       r = {1'b1, CLS_LOAD};
            6'h28, 6'h29, 6'h2B:                       r = {1'b1, CLS_STORE};
            6'h02, 6'h03:                              r = {1'b1, CLS_JUMP};
            default:                                   r = 4'b0;
        endcase
        return r;
    endfunction

    assign dec = decode(opcode, funct);

    // Lowest-index pending exception request wins; cause is index+1.
    always_comb begin
        req_cause = '0;
        for (int k = int'(N_EXC) - 1; k >= 0; k--) begin
            if (exc_req[k]) begin
                req_cause = CAUSE_W'(k + 1);
            end
        end
    end

    // Next state, wait counter and latched decode/cause values.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = '0;
        class_nxt = exec_class;
        cause_nxt = exc_cause;
        case (state)
            S_RESET: state_nxt = S_FETCH;
            S_FETCH: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_DECODE;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            S_DECODE: begin
                class_nxt = dec[2:0];
                if (dec[3]) begin
                    state_nxt = S_EXEC;
                end else begin
                    cause_nxt = '0;
                    state_nxt = S_EXC_SAVE;
                end
            end
            S_EXEC: begin
                if (|exc_req) begin
                    cause_nxt = req_cause;
                    state_nxt = S_EXC_SAVE;
                end else if (exec_done) begin
                    state_nxt = S_FETCH;
                end
            end
            S_EXC_SAVE: state_nxt = S_EXC_VEC;
            S_EXC_VEC: begin
                if (cnt == CNT_LAST) begin
                    state_nxt = S_FETCH;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: state_nxt = S_RESET;
        endcase
    end

    assign nxt_last = (cnt_nxt == CNT_LAST);

    // State register with outputs decoded from the upcoming state and count.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RESET;
            cnt          <= '0;
            exec_class   <= '0;
            exc_cause    <= '0;
            vec_addr     <= '0;
            pc_write     <= 1'b0;
            pc_src       <= 2'd0;
            ir_write     <= 1'b0;
            ab_write     <= 1'b0;
            epc_write    <= 1'b0;
            mem_addr_sel <= 2'd0;
            exec_start   <= 1'b0;
            reset_out    <= 1'b1;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            exec_class <= class_nxt;
            exc_cause  <= cause_nxt;
            if (state_nxt == S_EXC_SAVE) begin
                vec_addr <= VEC_BASE + 8'(cause_nxt);
            end
            reset_out    <= (state_nxt == S_RESET);
            ir_write     <= (state_nxt == S_FETCH) && nxt_last;
            pc_write     <= ((state_nxt == S_FETCH) || (state_nxt == S_EXC_VEC)) && nxt_last;
            pc_src       <= ((state_nxt == S_EXC_VEC) && nxt_last) ? 2'd1 : 2'd0;
            ab_write     <= (state_nxt == S_DECODE);
            epc_write    <= (state_nxt == S_EXC_SAVE);
            mem_addr_sel <= (state_nxt == S_EXC_VEC) ? 2'd2 : 2'd0;
            exec_start   <= (state_nxt == S_EXEC) && (state == S_DECODE);
        end
    end

endmodule

// File: doc/cpu_sequencer.md
# cpu_sequencer

Parametrised phase sequencer for the multicycle MIPS-subset CPU. It owns the fetch/decode/execute/exception skeleton and generalises it with a configurable memory latency, a configurable number of datapath exception sources with fixed priority, and a vectored exception entry. Per-instruction datapath steering is delegated to the execute engine through a start/done handshake. It sits between the instruction register and memory on one side and the execute engine and datapath muxes on the other.

## Interface
- MEM_WAIT, 1: extra memory read wait cycles, legal 0..15; every memory read phase lasts MEM_WAIT+1 cycles.
- N_EXC, 2: number of datapath exception sources; bit 0 = overflow, bit 1 = divide-by-zero.
- VEC_BASE, 8'd253: memory byte address of the exception vector table.
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high.
- opcode  in  6  IR[31:26].
- funct  in  6  IR[5:0].
- exec_done  in  1  execute engine has finished the current instruction.
- exc_req  in  N_EXC  datapath exception requests, level, valid while in EXEC.
- pc_write  out  1  load PC.
- pc_src  out  2  PC source: 0 = ALU (PC+4), 1 = zero-extended memory byte (vector).
- ir_write  out  1  load IR.
- ab_write  out  1  load A and B from the register file.
- epc_write  out  1  load EPC (datapath supplies PC-4).
- mem_addr_sel  out  2  memory address: 0 = PC, 2 = vec_addr; never 1 or 3 while this block drives it.
- vec_addr  out  8  VEC_BASE + exc_cause.
- exec_start  out  1  one-cycle pulse starting the execute engine.
- exec_class  out  3  0 R-ALU/shift, 1 I-ALU, 2 branch, 3 load, 4 store, 5 jump, 6 mult/div, 7 special (jr, mfhi, mflo, break, rte, xchg).
- exc_cause  out  $clog2(N_EXC+1)  latched cause: 0 = invalid opcode, k+1 = exc_req[k].
- reset_out  out  1  reset request to the stack-pointer/register-file init logic.

## Operation
- States: RESET, FETCH, DECODE, EXEC, EXC_SAVE, EXC_VEC. A wait counter of width $clog2(MEM_WAIT+1) counts within FETCH and EXC_VEC.
- All outputs are Moore-decoded from the state and counter. Outside the listed assertions every output is 0.
- The following are registered and hold their values until rewritten: exec_class, exc_cause, and (through exc_cause) vec_addr.
- RESET: reset_out = 1. Transition to FETCH on the next edge.
- FETCH: mem_addr_sel = 0 for all MEM_WAIT+1 cycles. On the last cycle, assert ir_write = 1, pc_write = 1 and pc_src = 0, then go to DECODE.
- DECODE, one cycle:
  - ab_write = 1; latch exec_class.
  - Legal opcodes: 0x00 with funct in {20,24,1A,18,08,10,12,00,04,2A,03,07,02,22,0D,13,05}, 0x08, 09, 04, 05, 06, 07, 01, 20, 21, 0F, 23, 28, 29, 0A, 2B, 02, 03.
  - Legal opcode: go to EXEC.
  - Illegal opcode or illegal funct: set exc_cause = 0 and go to EXC_SAVE. exec_start is never asserted for it.
- EXEC:
  - exec_start = 1 only in the first EXEC cycle.
  - Stay in EXEC until exec_done = 1; exec_done in the first cycle is legal.
  - Any exc_req bit high in an EXEC cycle: latch cause = (lowest set index)+1 and go to EXC_SAVE, regardless of exec_done.
  - Otherwise exec_done returns to FETCH.
- EXC_SAVE, one cycle: epc_write = 1. Go to EXC_VEC.
- EXC_VEC: mem_addr_sel = 2 for MEM_WAIT+1 cycles. On the last cycle, assert pc_write = 1 and pc_src = 1, then go to FETCH.
- exc_req is ignored in every state except EXEC. Exceptions never nest.

## Timing
- Async reset:
  - State goes to RESET immediately; all outputs, counter, exec_class and exc_cause go to 0; reset_out goes to 1.
  - Reset asserted mid-fetch or mid-vector aborts the read with no pc_write.
  - reset_out stays 1 through the first rising edge after deassertion, then drops with entry to FETCH.
- Instruction cost: MEM_WAIT+1 (FETCH) + 1 (DECODE) + N (EXEC, N ≥ 1 cycles up to and including exec_done).
- Exception entry cost, from the cycle after the detection edge to the first FETCH cycle: 1 + MEM_WAIT+1.
- The wait counter resets to 0 on entering FETCH and EXC_VEC; it never wraps.
- MEM_WAIT = 0: the read phases are single-cycle, and write strobes coincide with the address cycle.

## Test plan
- Reset release, MEM_WAIT=1:
  - reset_out = 1 for exactly one edge after deassertion.
  - FETCH: mem_addr_sel = 0 for 2 cycles; ir_write and pc_write pulse in cycle 2.
  - Then ab_write for 1 cycle.
- add (opcode 0, funct 0x20), exec_done 3 cycles after exec_start: exec_class = 0, exec_start pulses once, FETCH resumes the cycle after exec_done.
- opcode 0x3F: exc_cause = 0, no exec_start, epc_write pulse, vec_addr = 253, pc_write with pc_src = 1 after MEM_WAIT+1 cycles.
- addi with exc_req = 2'b11 during EXEC: exc_cause = 1 (overflow wins), vec_addr = 254. exc_req asserted again during EXC_VEC: ignored.
- div with exc_req[1]: exc_cause = 2, vec_addr = 255. Sweep MEM_WAIT = 0 and 3; check vector read lengths of 1 and 4 cycles.
- Reset asserted in the middle of FETCH cycle 1 and again mid-EXC_VEC: outputs are 0 immediately, reset_out = 1, no pc_write.
